serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (1..16).
REQ-002 SHALL have parameter DIV, default 4, clock cycles per serial bit (>=1).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  in  DATA_W  parallel word to send.
REQ-006 SHALL have port in_valid  in  1  in_data is valid.
REQ-007 SHALL have port in_ready  out  1  block accepts a word this cycle.
REQ-008 SHALL have port txd  out  1  serial line; idle level 1.
REQ-009 SHALL have port busy  out  1  frame in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-012 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, capture in_data into a shift register, and enter START.
REQ-013 SHALL drive in_ready=1 only in IDLE with reset=0; in_ready SHALL be combinational from state.
REQ-014 SHALL hold txd=0 for exactly DIV cycles in START, beginning the cycle after acceptance.
REQ-015 SHALL send DATA_W data bits LSB first in DATA, each held for exactly DIV cycles.
REQ-016 SHALL hold txd=1 for DIV cycles in STOP, then return to IDLE.
REQ-017 SHALL count bit periods with a divider counter of width max(1,clog2(DIV)), which reloads at each bit boundary; the bit counter width SHALL be clog2(DATA_W+1).
REQ-018 SHALL pulse done=1 for the single last cycle of STOP.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL keep txd=1 in IDLE.
REQ-021 SHALL ignore in_valid and in_data outside IDLE; the captured word SHALL NOT change mid-frame.
REQ-022 SHALL guarantee at least one IDLE cycle between frames, so the minimum frame-to-frame period is frame_len+1 cycles.
REQ-023 SHALL, for DIV=1, change txd every cycle with no extra stall cycles.

Reset
REQ-024 SHALL, while reset=1 at a rising edge, force state=IDLE, txd=1, busy=0, done=0 and clear the counters and shift register.
REQ-025 SHALL abort any frame in progress on reset; txd SHALL return to 1 on the next edge, and done SHALL NOT pulse.
REQ-026 SHALL hold in_ready=0 during reset, so no word is accepted in a cycle with reset=1.

Configuration
REQ-027 SHALL, with SERIAL_TX_PARITY_EN defined, insert PARITY between DATA and STOP for DIV cycles with txd = XOR of the data bits (even parity).
REQ-028 SHALL, without SERIAL_TX_PARITY_EN, omit the PARITY state and all parity logic.
REQ-029 SHALL have frame_len = (DATA_W+2)*DIV cycles, or (DATA_W+3)*DIV with parity.

Structure
REQ-030 SHALL place the state encoding typedef and the constants IDLE_LEVEL=1, START_LEVEL=0 and STOP_LEVEL=1 in a shared package, serial_pkg.
REQ-031 SHALL contain one sub-module, serial_baud_div, which produces a one-cycle bit_tick every DIV cycles, restarted on acceptance and on reset.
REQ-032 SHALL be fully synthesizable, with no delays or simulation-only constructs outside the verification bench.

Verification
REQ-033 SHALL cover: DIV=4, send 0xA5 -> txd = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; done high in cycle 40 after acceptance.
REQ-034 SHALL cover: with parity, send 0xA5 -> parity bit 0 for 4 cycles before stop; send 0x01 -> parity bit 1; frame 44 cycles.
REQ-035 SHALL cover: in_valid held high for 3 words -> each accepted only in IDLE, one idle cycle between frames, words sent in order.
REQ-036 SHALL cover: reset asserted at cycle 10 of a frame -> txd=1, busy=0 next cycle, no done pulse, in_ready=1 after reset is released.
REQ-037 SHALL cover: in_data changed mid-frame -> serial bits match the word captured at acceptance.
REQ-038 SHALL cover: DIV=1, send 0xFF -> txd = 0, then eight 1s, then 1; done in cycle 10.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and line levels shared by serial_tx and its sub-module.
// Defining SERIAL_TX_PARITY_EN adds the PARITY state to the encoding.
package serial_pkg;
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/serial_baud_div.sv
// serial_baud_div: one-cycle bit_tick every DIV cycles, marking the last cycle of a bit period.
module serial_baud_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        bit_tick = cnt_q == CW'(DIV - 1);
        cnt_d    = (restart || bit_tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter (start, DATA_W bits LSB first, stop).
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(DATA_W + 1);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              bit_tick;
    logic              accept;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    serial_baud_div #(.DIV(DIV)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (accept),
        .bit_tick (bit_tick)
    );
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        txd     = IDLE_LEVEL;
        done    = 1'b0;
        busy    = state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    sh_d    = in_data;
                    bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            START: begin
                txd = START_LEVEL;
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                txd = sh_q[0];
                if (bit_tick) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    if (bit_q == BW'(DATA_W - 1)) state_d = PARITY;
`else
                    if (bit_q == BW'(DATA_W - 1)) state_d = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                txd = par_q;
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                txd  = STOP_LEVEL;
                done = bit_tick;
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx at DIV=4 and DIV=1; expected words are queued
// at acceptance and compared against whole captured frames (txd, done and busy per cycle).
module tb_serial_tx;
    localparam int DW = 8;
    localparam int DV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FL  = NB * DV;
    localparam int FL1 = NB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0, in_data1 = '0;
    logic          in_valid = 1'b0, in_valid1 = 1'b0;
    logic          in_ready, txd, busy, done;
    logic          in_ready1, txd1, busy1, done1;
    int            total = 0, bad = 0, cyc = 0;
    logic [DW-1:0] exp_q[$], exp1_q[$];

    serial_tx #(.DATA_W(DW), .DIV(DV)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .txd(txd), .busy(busy), .done(done)
    );
    serial_tx #(.DATA_W(DW), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .txd(txd1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle txd of a full frame; bit 0 is the first cycle after acceptance.
    function automatic logic [63:0] frame_bits(input logic [DW-1:0] w, input int div);
        logic [63:0] f = '0;
        int k = 0;
        logic b;
        for (int i = 0; i < NB; i++) begin
            if (i == 0) b = 1'b0;
            else if (i <= DW) b = w[i-1];
            else b = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            if (i == DW + 1) b = ^w;
`endif
            for (int j = 0; j < div; j++) begin
                f[k] = b;
                k++;
            end
        end
        return f;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [DW-1:0] w, input bit expect_frame);
        wait_ready();
        in_data  = w;
        in_valid = 1'b1;
        if (expect_frame) exp_q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic run_div1(input logic [DW-1:0] w);
        logic [63:0] tx_v = '0, dn_v = '0;
        int n = 0;
        while (in_ready1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_data1  = w;
        in_valid1 = 1'b1;
        exp1_q.push_back(w);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_data1  = ~w;
        for (int c = 0; c < FL1; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            tx_v[c] = txd1;
            dn_v[c] = done1;
        end
        w = exp1_q.pop_front();
        chk("div1_txd", tx_v, frame_bits(w, 1));
        chk("div1_done", dn_v, 64'd1 << (FL1 - 1));
        @(posedge clk);
        #1;
        chk("div1_idle_txd", txd1, 1);
    endtask

    // Scoreboard consumer: captures each frame of u_dut and compares it to the next queued word.
    initial begin
        logic [63:0] tx_v, dn_v, bs_v;
        logic [DW-1:0] w;
        bit ab;
        forever begin
            @(posedge clk);
            #1;
            if (busy === 1'b1 && !reset) begin
                tx_v = '0; dn_v = '0; bs_v = '0; ab = 1'b0;
                for (int c = 0; c < FL; c++) begin
                    if (c > 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (reset) begin
                        ab = 1'b1;
                        break;
                    end
                    tx_v[c] = txd;
                    dn_v[c] = done;
                    bs_v[c] = busy;
                end
                if (!ab) begin
                    if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                    else begin
                        w = exp_q.pop_front();
                        chk("frame_txd", tx_v, frame_bits(w, DV));
                        chk("frame_done", dn_v, 64'd1 << (FL - 1));
                        chk("frame_busy", bs_v, (64'd1 << FL) - 1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] words[3];
        int acc[3];
        int dn;
        words = '{8'h3C, 8'hE7, 8'h42};
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        chk("idle_txd", txd, 1);
        send(8'hA5, 1'b1);
        chk("busy_after_accept", busy, 1);
        chk("ready_in_frame", in_ready, 0);
        wait_drain();
        send(8'h01, 1'b1);
        wait_drain();
        send(8'h80, 1'b1);
        wait_drain();
        // in_valid held high: each word is taken only in IDLE, one idle cycle apart
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = words[k];
            wait_ready();
            exp_q.push_back(words[k]);
            acc[k] = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("gap01", 64'(acc[1] - acc[0]), FL + 1);
        chk("gap12", 64'(acc[2] - acc[1]), FL + 1);
        wait_drain();
        // in_data and in_valid toggled mid-frame must not disturb the captured word
        send(8'h3C, 1'b1);
        in_data  = 8'hC3;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
        // reset in the middle of a frame aborts it without a done pulse
        send(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_txd", txd, 1);
        chk("abort_done", done, 0);
        chk("abort_ready", in_ready, 0);
        reset = 1'b0;
        dn = 0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        for (int c = 0; c < FL; c++) begin
            dn = dn | int'(done) | int'(busy);
            @(negedge clk);
        end
        chk("abort_quiet", 64'(dn), 0);
        send(8'h96, 1'b1);
        wait_drain();
        run_div1(8'hFF);
        run_div1(8'h96);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
